// File: rtl/qbus_pwrseq_pkg.sv
// ----------------------------------------------------------------------------
// qbus_pwrseq_pkg
// Shared types and constants for the Q-bus power-line sequencer.
//   state_e          : sequencer FSM states
//   *_CYCLES_DEF     : default phase lengths for a 2.5 MHz clock
//   TRIPS_MAX        : saturation value of the trip counter
//   max3()           : largest of three ints, used to size the shared counter
// ----------------------------------------------------------------------------
package qbus_pwrseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PFAIL = 2'd1,
        ST_DCLOW = 2'd2,
        ST_DCUP  = 2'd3
    } state_e;

    localparam int PF_CYCLES_DEF  = 10000;   // 4 ms
    localparam int DCL_CYCLES_DEF = 10;      // 4 us
    localparam int UP_CYCLES_DEF  = 175000;  // 70 ms

    localparam int TRIPS_MAX = 255;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/qbus_pwrseq.sv
// ----------------------------------------------------------------------------
// qbus_pwrseq
// Turns a sanity-timer expiry request into a Q-bus reboot sequence on the
// open-drain BPOK/BDCOK lines (BPOK drops first, BDCOK returns first) and
// keeps a saturating count of sequences started.
//
// Build option: define QBUS_PWRSEQ_BPOK_EN for the full PFAIL/DCLOW/DCUP
// sequence. Without it only BDCOK is pulsed and bpok_oe is tied low.
//
// Ports:
//   clock      in   system clock (2.5 MHz)
//   nrst       in   asynchronous active-low reset
//   req        in   expiry request; a rising edge starts a sequence
//   ena        in   start permission; does not abort a running sequence
//   trips_clr  in   one-cycle clear of trips
//   bpok_oe    out  1 = pull BPOK low
//   bdcok_oe   out  1 = pull BDCOK low
//   busy       out  sequence in progress
//   trips      out  saturating count of sequences started
// ----------------------------------------------------------------------------
module qbus_pwrseq
    import qbus_pwrseq_pkg::*;
#(
    parameter int PF_CYCLES  = PF_CYCLES_DEF,
    parameter int DCL_CYCLES = DCL_CYCLES_DEF,
    parameter int UP_CYCLES  = UP_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       nrst,
    input  logic       req,
    input  logic       ena,
    input  logic       trips_clr,
    output logic       bpok_oe,
    output logic       bdcok_oe,
    output logic       busy,
    output logic [7:0] trips
);

    // One down counter is shared by all phases, so it is sized by the longest.
    localparam int MAX_CYCLES = max3(PF_CYCLES, DCL_CYCLES, UP_CYCLES);
    localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DCL_LOAD = CNT_W'(DCL_CYCLES - 1);
`ifdef QBUS_PWRSEQ_BPOK_EN
    localparam logic [CNT_W-1:0] PF_LOAD  = CNT_W'(PF_CYCLES - 1);
    localparam logic [CNT_W-1:0] UP_LOAD  = CNT_W'(UP_CYCLES - 1);
`endif

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_req_q;
    logic             r_bdcok_oe;
    logic [7:0]       r_trips;
    logic             w_start;
    logic             w_cnt_zero;

    // Edge-detect on req; r_req_q resets high so a req already asserted out
    // of reset cannot trigger a sequence.
    assign w_start    = (r_state == ST_IDLE) && req && !r_req_q && ena;
    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        w_next_state = r_state;
        w_next_cnt   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_next_cnt = '0;
                if (w_start) begin
`ifdef QBUS_PWRSEQ_BPOK_EN
                    w_next_state = ST_PFAIL;
                    w_next_cnt   = PF_LOAD;
`else
                    w_next_state = ST_DCLOW;
                    w_next_cnt   = DCL_LOAD;
`endif
                end
            end
`ifdef QBUS_PWRSEQ_BPOK_EN
            ST_PFAIL: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_DCLOW;
                    w_next_cnt   = DCL_LOAD;
                end
            end
`endif
            ST_DCLOW: begin
                // Stays here with the counter parked at 0 while req is held.
                if (w_cnt_zero && !req) begin
`ifdef QBUS_PWRSEQ_BPOK_EN
                    w_next_state = ST_DCUP;
                    w_next_cnt   = UP_LOAD;
`else
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
`endif
                end
            end
`ifdef QBUS_PWRSEQ_BPOK_EN
            ST_DCUP: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_req_q    <= 1'b1;
            r_bdcok_oe <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_req_q    <= req;
            r_bdcok_oe <= (w_next_state == ST_DCLOW);
        end
    end

    // A clear coincident with a start yields 1, since that start still counts.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_trips <= '0;
        end else if (trips_clr) begin
            r_trips <= w_start ? 8'd1 : 8'd0;
        end else if (w_start && (r_trips != 8'(TRIPS_MAX))) begin
            r_trips <= r_trips + 8'd1;
        end
    end

`ifdef QBUS_PWRSEQ_BPOK_EN
    logic r_bpok_oe;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_bpok_oe <= 1'b0;
        end else begin
            r_bpok_oe <= (w_next_state != ST_IDLE);
        end
    end

    assign bpok_oe = r_bpok_oe;
`else
    assign bpok_oe = 1'b0;
`endif

    assign bdcok_oe = r_bdcok_oe;
    assign busy     = (r_state != ST_IDLE);
    assign trips    = r_trips;

endmodule

// File: tb/tb_qbus_pwrseq.sv
// ----------------------------------------------------------------------------
// tb_qbus_pwrseq
// Self-checking bench for qbus_pwrseq (PF=4, DCL=3, UP=5). A cycle model
// pushes the expected {bpok_oe, bdcok_oe, busy, trips} after each rising edge;
// the falling edge pops it and compares against the DUT. Directed checks
// cover phase lengths, trip saturation/clear and asynchronous reset.
// Follows QBUS_PWRSEQ_BPOK_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_qbus_pwrseq;

    localparam int DCL = 3;
`ifdef QBUS_PWRSEQ_BPOK_EN
    localparam int M_PF = 4;
    localparam int M_UP = 5;
    localparam int EXP_BP = 4 + 3 + 5;
`else
    localparam int M_PF = 0;
    localparam int M_UP = 0;
    localparam int EXP_BP = 0;
`endif
    localparam int SEQ_LEN = M_PF + DCL + M_UP;

    logic       clock = 1'b0;
    logic       nrst = 1'b0;
    logic       req = 1'b1;
    logic       ena = 1'b1;
    logic       trips_clr = 1'b0;
    logic       bpok_oe;
    logic       bdcok_oe;
    logic       busy;
    logic [7:0] trips;

    int n_vec = 0;
    int n_err = 0;

    qbus_pwrseq #(
        .PF_CYCLES (4),
        .DCL_CYCLES(3),
        .UP_CYCLES (5)
    ) dut (
        .clock    (clock),
        .nrst     (nrst),
        .req      (req),
        .ena      (ena),
        .trips_clr(trips_clr),
        .bpok_oe  (bpok_oe),
        .bdcok_oe (bdcok_oe),
        .busy     (busy),
        .trips    (trips)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [10:0] sb[$];
    bit          m_busy  = 1'b0;
    bit          m_req_q = 1'b1;
    int          m_t     = 0;
    int          m_dcl   = DCL;
    int          m_trips = 0;

    always @(posedge clock or negedge nrst) begin
        bit          st;
        logic        e_bp;
        logic        e_bdc;
        if (!nrst) begin
            m_busy  = 1'b0;
            m_req_q = 1'b1;
            m_t     = 0;
            m_dcl   = DCL;
            m_trips = 0;
            sb.delete();
        end else begin
            st = !m_busy && req && !m_req_q && ena;
            if (m_busy) begin
                // Last BDCOK-low cycle with req still high: low phase stretches.
                if (m_t == M_PF + m_dcl - 1 && req) m_dcl++;
                m_t++;
                if (m_t == M_PF + m_dcl + M_UP) m_busy = 1'b0;
            end else if (st) begin
                m_busy = 1'b1;
                m_t    = 0;
                m_dcl  = DCL;
            end
            if (trips_clr)                 m_trips = st ? 1 : 0;
            else if (st && m_trips < 255)  m_trips++;
            m_req_q = req;
            e_bp  = (EXP_BP != 0) && m_busy;
            e_bdc = m_busy && (m_t >= M_PF) && (m_t < M_PF + m_dcl);
            sb.push_back({e_bp, e_bdc, m_busy, 8'(m_trips)});
        end
    end

    always @(negedge clock) begin
        logic [10:0] exp;
        if (nrst && sb.size() > 0) begin
            exp = sb.pop_front();
            check("cycle", {21'd0, bpok_oe, bdcok_oe, busy, trips}, {21'd0, exp});
        end
    end

    // ---------------- stimulus helpers ----------------
    // One-cycle req pulse, then a 20-cycle observation window.
    task automatic pulse_measure(output int n_bp, output int n_bdc, output int n_busy,
                                 output int off);
        int f_busy;
        int f_bdc;
        n_bp = 0; n_bdc = 0; n_busy = 0; f_busy = -1; f_bdc = -1;
        @(negedge clock); req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) req = 1'b0;
            if (bpok_oe)  n_bp++;
            if (bdcok_oe) begin n_bdc++; if (f_bdc < 0) f_bdc = i; end
            if (busy)     begin n_busy++; if (f_busy < 0) f_busy = i; end
        end
        off = f_bdc - f_busy;
    endtask

    initial begin
        int n_bp, n_bdc, n_busy, off;
        bit seen;

        // Reset held with req high, then released with req still high.
        repeat (3) @(negedge clock);
        check("rst_bpok",  {31'd0, bpok_oe},  32'd0);
        check("rst_bdcok", {31'd0, bdcok_oe}, 32'd0);
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_trips", {24'd0, trips},    32'd0);
        #2 nrst = 1'b1;
        repeat (6) @(negedge clock);
        check("rst_no_retrigger", {31'd0, busy}, 32'd0);
        req = 1'b0;
        repeat (2) @(negedge clock);

        // Basic single-cycle request.
        pulse_measure(n_bp, n_bdc, n_busy, off);
        check("pulse_bpok_len",  n_bp,   EXP_BP);
        check("pulse_bdcok_len", n_bdc,  DCL);
        check("pulse_busy_len",  n_busy, SEQ_LEN);
        check("pulse_bdcok_off", off,    M_PF);
        check("pulse_trips",     {24'd0, trips}, 32'd1);

        // req held 10 cycles stretches the BDCOK-low phase.
        n_bdc = 0;
        @(negedge clock); req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 9) req = 1'b0;
`ifdef QBUS_PWRSEQ_BPOK_EN
            // Second request lands in DCUP and must be ignored.
            if (i == 12) req = 1'b1;
            if (i == 13) req = 1'b0;
`endif
            if (bdcok_oe) n_bdc++;
        end
        check("hold_bdcok_len", n_bdc, 10 - M_PF);
        check("hold_trips", {24'd0, trips}, 32'd2);
        check("hold_idle",  {31'd0, busy},  32'd0);

        // ena low blocks starts.
        ena = 1'b0;
        pulse_measure(n_bp, n_bdc, n_busy, off);
        check("ena0_busy",  n_busy, 0);
        check("ena0_trips", {24'd0, trips}, 32'd2);
        ena = 1'b1;

        // ena dropped mid-sequence does not abort.
        n_busy = 0;
        @(negedge clock); req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) req = 1'b0;
            if (i == 1) ena = 1'b0;
            if (busy) n_busy++;
        end
        check("ena_drop_busy", n_busy, SEQ_LEN);
        check("ena_drop_trips", {24'd0, trips}, 32'd3);
        ena = 1'b1;

        // Saturation of the trip counter.
        for (int k = 0; k < 300; k++) begin
            @(negedge clock); req = 1'b1;
            @(negedge clock); req = 1'b0;
            repeat (SEQ_LEN + 2) @(negedge clock);
        end
        check("trips_sat", {24'd0, trips}, 32'd255);

        @(negedge clock); trips_clr = 1'b1;
        @(negedge clock); trips_clr = 1'b0;
        check("trips_clr", {24'd0, trips}, 32'd0);

        @(negedge clock); trips_clr = 1'b1; req = 1'b1;
        @(negedge clock); trips_clr = 1'b0; req = 1'b0;
        check("trips_clr_start", {24'd0, trips}, 32'd1);
        check("trips_clr_busy",  {31'd0, busy},  32'd1);
        repeat (SEQ_LEN + 2) @(negedge clock);

        // Asynchronous reset in the BDCOK-low phase.
        @(negedge clock); req = 1'b1;
        @(negedge clock); req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bdcok_oe) seen = 1'b1;
            else @(negedge clock);
        end
        check("dclow_reached", {31'd0, seen}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("async_bpok",  {31'd0, bpok_oe},  32'd0);
        check("async_bdcok", {31'd0, bdcok_oe}, 32'd0);
        check("async_busy",  {31'd0, busy},     32'd0);
        check("async_trips", {24'd0, trips},    32'd0);
        @(negedge clock); #2 nrst = 1'b1;
        repeat (3) @(negedge clock);

        pulse_measure(n_bp, n_bdc, n_busy, off);
        check("post_rst_bdcok_len", n_bdc, DCL);
        check("post_rst_trips", {24'd0, trips}, 32'd1);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
